// File: rtl/dmem_access_unit.sv
// ============================================================================
// Module  : dmem_access_unit
// Brief   : Execute/memory-stage load/store engine. Issues one data-bus
//           transaction per decoded load/store, stalls the pipeline until it
//           finishes, extends load data and reports access faults.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_unit #(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dren,
    input  logic        dwen,
    input  logic [3:0]  byte_en,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        bus_busy,
    input  logic        bus_error,
    input  logic [31:0] bus_rdata,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byte_en,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata_ext,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;

    localparam logic [1:0] c_sz_byte = 2'd0;
    localparam logic [1:0] c_sz_half = 2'd1;
    localparam logic [1:0] c_sz_word = 2'd2;

    localparam logic [1:0] c_fc_align    = 2'b00;
    localparam logic [1:0] c_fc_conflict = 2'b01;
    localparam logic [1:0] c_fc_bus      = 2'b10;
    localparam logic [1:0] c_fc_timeout  = 2'b11;

    localparam logic [TO_W-1:0] c_to_last = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [TO_W-1:0] r_count;
    logic            r_is_load;
    logic [1:0]      r_size;
    logic            r_sign;
    logic [1:0]      r_off;
    logic [29:0]     r_word_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic            r_fault;
    logic [1:0]      r_fault_code;
    logic [31:0]     r_rdata_ext;

    logic            w_req;
    logic [1:0]      w_size;
    logic            w_sign;
    logic            w_size_ok;
    logic            w_misalign;
    logic            w_illegal;
    logic [1:0]      w_ill_code;
    logic            w_wd_expire;
    logic [7:0]      w_rbyte;
    logic [15:0]     w_rhalf;
    logic [31:0]     w_load_ext;

    assign w_req = dren | dwen;

    // Request decode: size/sign of the access and the illegal-request priority chain.
    always_comb begin
        w_size     = c_sz_word;
        w_sign     = 1'b0;
        w_size_ok  = 1'b0;
        w_illegal  = 1'b0;
        w_ill_code = c_fc_align;
        if (dwen) begin
            case (byte_en)
                4'b0001: begin w_size = c_sz_byte; w_size_ok = 1'b1; end
                4'b0011: begin w_size = c_sz_half; w_size_ok = 1'b1; end
                4'b1111: begin w_size = c_sz_word; w_size_ok = 1'b1; end
                default: w_size_ok = 1'b0;
            endcase
        end else begin
            case (load_type)
                3'b000:  begin w_size = c_sz_byte; w_sign = 1'b1; w_size_ok = 1'b1; end
                3'b001:  begin w_size = c_sz_half; w_sign = 1'b1; w_size_ok = 1'b1; end
                3'b010:  begin w_size = c_sz_word; w_size_ok = 1'b1; end
                3'b100:  begin w_size = c_sz_byte; w_size_ok = 1'b1; end
                3'b101:  begin w_size = c_sz_half; w_size_ok = 1'b1; end
                default: w_size_ok = 1'b0;
            endcase
        end
        w_misalign = ((w_size == c_sz_half) && addr[0]) ||
                     ((w_size == c_sz_word) && (addr[1:0] != 2'b00));
        if (dren && dwen) begin
            w_illegal  = 1'b1;
            w_ill_code = c_fc_conflict;
        end else if (!w_size_ok || w_misalign) begin
            w_illegal  = 1'b1;
            w_ill_code = c_fc_align;
        end
    end

    assign w_wd_expire = (TIMEOUT != 0) && (r_count == c_to_last);

    assign w_rbyte = bus_rdata[{r_off, 3'b000} +: 8];
    assign w_rhalf = bus_rdata[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = bus_rdata;
        case (r_size)
            c_sz_byte: w_load_ext = {{24{r_sign & w_rbyte[7]}}, w_rbyte};
            c_sz_half: w_load_ext = {{16{r_sign & w_rhalf[15]}}, w_rhalf};
            default:   w_load_ext = bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_req) begin
                    w_state_next = w_illegal ? c_st_resp : c_st_access;
                end
            end
            c_st_access: begin
                if (!bus_busy || w_wd_expire) begin
                    w_state_next = c_st_resp;
                end
            end
            c_st_resp: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Output logic; bus signals are only non-zero while the transaction is open.
    always_comb begin
        bus_ren     = 1'b0;
        bus_wen     = 1'b0;
        bus_addr    = 32'd0;
        bus_wdata   = 32'd0;
        bus_byte_en = 4'd0;
        stall       = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        case (r_state)
            c_st_idle: begin
                stall = w_req;
            end
            c_st_access: begin
                bus_ren     = r_is_load;
                bus_wen     = ~r_is_load;
                bus_addr    = {r_word_addr, 2'b00};
                bus_wdata   = r_wdata;
                bus_byte_en = r_be;
                stall       = 1'b1;
            end
            c_st_resp: begin
                done  = 1'b1;
                fault = r_fault;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign rdata_ext  = r_rdata_ext;
    assign fault_code = r_fault_code;

    // Transaction context, watchdog and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_is_load    <= 1'b0;
            r_size       <= c_sz_byte;
            r_sign       <= 1'b0;
            r_off        <= 2'b00;
            r_word_addr  <= 30'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
            r_rdata_ext  <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_count <= '0;
                    if (w_req) begin
                        r_is_load    <= ~dwen;
                        r_size       <= w_size;
                        r_sign       <= w_sign;
                        r_off        <= addr[1:0];
                        r_word_addr  <= addr[31:2];
                        r_wdata      <= wdata << {addr[1:0], 3'b000};
                        r_be         <= dwen ? (byte_en << addr[1:0]) : 4'b1111;
                        r_fault      <= w_illegal;
                        r_fault_code <= w_illegal ? w_ill_code : 2'b00;
                        r_rdata_ext  <= 32'd0;
                    end
                end
                c_st_access: begin
                    r_count <= r_count + 1'b1;
                    if (!bus_busy) begin
                        if (bus_error) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= c_fc_bus;
                        end else if (r_is_load) begin
                            r_rdata_ext <= w_load_ext;
                        end
                    end else if (w_wd_expire) begin
                        r_fault      <= 1'b1;
                        r_fault_code <= c_fc_timeout;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
